sfu_lut_interp: RTL
===================

# sfu_lut_interp

Programmable, multi-lane lookup table with linear interpolation for the SFU. It is the parametrised successor of the fixed dual-port exponent-table ROM. Table contents are written at runtime through a config port instead of being hard-coded. Each of `NUM_PORTS` lanes maps an unsigned fixed-point input to an interpolated table value through a 2-stage valid/ready pipeline.

## Interface
- `NUM_PORTS`, 2: lookup lanes, processed in lock-step (SIMD).
- `ADDR_WIDTH`, 5: table index width; depth = 2^ADDR_WIDTH.
- `FRAC_WIDTH`, 4: fractional input bits used for interpolation.
- `DATA_WIDTH`, 16: table entry and result width, unsigned.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  ADDR_WIDTH  table write index.
- `cfg_wdata`  in  DATA_WIDTH  table write data.
- `in_valid`  in  1  input beat valid, common to all lanes.
- `in_ready`  out  1  block accepts an input beat.
- `in_x`  in  NUM_PORTS*(ADDR_WIDTH+FRAC_WIDTH)  packed inputs; lane i occupies bits [i*IW +: IW], where IW = ADDR_WIDTH+FRAC_WIDTH.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts the result beat.
- `out_y`  out  NUM_PORTS*DATA_WIDTH  packed results; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Table: a register array of 2^ADDR_WIDTH x DATA_WIDTH entries. `rst` clears every entry to 0.
- Table write: when `cfg_we`=1 at a clock edge, `table[cfg_addr]` is set to `cfg_wdata`. Writes are accepted at any time, including while the pipeline is stalled.
- Lane decode: address `a` = x[IW-1:FRAC_WIDTH]; fraction `f` = x[FRAC_WIDTH-1:0].
- Stage 1 captures, on accept, per lane: `t0`=table[a], `t1`=table[a+1], and `f`.
  - Boundary: when a = 2^ADDR_WIDTH-1, `t1`=`t0`. The upper address clamps; it never wraps to entry 0.
- Read-before-write: a lookup accepted in the same cycle as a write to the same index reads the old value.
- Stage 2 computes, per lane: d = t1 - t0 as a signed DATA_WIDTH+1 value; p = d*f as a signed DATA_WIDTH+1+FRAC_WIDTH value; y = t0 + (p >>> FRAC_WIDTH).
  - The shift is arithmetic, so the result is floored.
  - y always lies between t0 and t1, so there is no overflow; y is truncated to DATA_WIDTH.
- Handshake: `stall` = `out_valid` & ~`out_ready`; `in_ready` = ~`stall`.
  - A beat is accepted when `in_valid` & `in_ready`.
  - Both stages advance only when ~`stall`. Bubbles propagate as valid=0.
- While stalled, `out_y` and `out_valid` hold their values. The stage-1 contents hold as well.
- All lanes share one valid bit; lanes never diverge.

## Timing
- Reset values: `out_valid`=0, `out_y`=0, `in_ready`=1, stage-1 valid=0, all table entries 0.
- Latency: the result for a beat accepted at edge N is presented with `out_valid`=1 after edge N+2, given no stall. Throughput is 1 beat/cycle.
- `in_ready` is combinational from `out_valid` and `out_ready`; there is no other combinational in-to-out path.
- A table write at edge N is visible to lookups accepted at edge N+1 or later.
- `rst` asserted mid-operation: the outputs and the table clear immediately (asynchronously); in-flight beats are dropped with no output.
- Simultaneous accept and output pop in a full pipeline: no bubble inserted.

## Configuration
- `SFU_LUT_INTERP_EN` defined: the linear interpolation described above.
- Not defined: nearest-lower output, y = t0. The `t1` read, the subtractor and the multiplier are not built. Latency stays 2 cycles and the handshake is identical, so the block remains a drop-in replacement.

## Test plan
All scenarios use default parameters with `SFU_LUT_INTERP_EN` defined, unless noted otherwise.
- Rising interpolation: write table[3]=0x08D7, table[4]=0x0ABA; lane0 x=0x038 -> lane0 y=0x09C8 two cycles after accept.
- Falling interpolation with floor: write table[16]=0x160C, table[17]=0x15F2; lane1 x=0x10C -> lane1 y=0x15F8.
- Clamp at top: write table[31]=0x0004; x=0x1FF on both lanes -> y=0x0004; table[0] has no effect.
- Macro undefined: table[3]=0x08D7; x=0x038 -> y=0x08D7 with the same 2-cycle latency.
- Back-pressure: stream 4 beats with `out_ready`=0 for 3 cycles after the first result -> `in_ready`=0 during the stall, `out_y` held, all 4 results emitted in order with none lost or duplicated.
- Reset mid-stream: assert `rst` while `out_valid`=1 -> `out_valid`=0, `out_y`=0 at once. After release, lookup x=0x038 -> y=0x0000 because the table was cleared. Also check that a same-cycle write to 3 with lookup at 3 returns the old value.

Source files
------------

// File: rtl/sfu_lut_interp.sv
// Runtime-programmable multi-lane lookup table for the SFU, 3-register valid/ready pipeline.
// Define SFU_LUT_INTERP_EN for linear interpolation; without it, each lane returns the nearest-lower entry.
module sfu_lut_interp #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FRAC_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           cfg_we,
  input  logic [ADDR_WIDTH-1:0]                          cfg_addr,
  input  logic [DATA_WIDTH-1:0]                          cfg_wdata,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [NUM_PORTS*(ADDR_WIDTH+FRAC_WIDTH)-1:0]   in_x,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]                out_y
);

  localparam int unsigned IW    = ADDR_WIDTH + FRAC_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0]           table_q [DEPTH];
  logic                            stall;

  logic [DATA_WIDTH-1:0]           rd_t0 [NUM_PORTS];
  logic                            s1_valid_q;
  logic [DATA_WIDTH-1:0]           s1_t0_q [NUM_PORTS];
  logic                            s2_valid_q;
  logic [DATA_WIDTH-1:0]           s2_t0_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0]           y_d [NUM_PORTS];
  logic                            out_valid_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] out_y_q;

`ifdef SFU_LUT_INTERP_EN
  localparam int unsigned PW = DATA_WIDTH + 1 + FRAC_WIDTH;
  logic [DATA_WIDTH-1:0]           rd_t1 [NUM_PORTS];
  logic [FRAC_WIDTH-1:0]           rd_f [NUM_PORTS];
  logic [DATA_WIDTH-1:0]           s1_t1_q [NUM_PORTS];
  logic [FRAC_WIDTH-1:0]           s1_f_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0]           mul_dy [NUM_PORTS];
  logic [DATA_WIDTH-1:0]           s2_dy_q [NUM_PORTS];
`else
  logic [NUM_PORTS-1:0]            unused_frac;
`endif

  // Global back-pressure: every stage holds while the output beat is not taken.
  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

  // Table storage; writes are independent of the lookup handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_we) begin
      table_q[cfg_addr] <= cfg_wdata;
    end
  end

  // Per-lane table read; the upper neighbour clamps at the last entry.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] lane_a;
    assign lane_a   = in_x[g*IW+FRAC_WIDTH +: ADDR_WIDTH];
    assign rd_t0[g] = table_q[lane_a];
`ifdef SFU_LUT_INTERP_EN
    assign rd_t1[g] = (lane_a == ADDR_MAX) ? table_q[lane_a]
                                           : table_q[lane_a + ADDR_WIDTH'(1)];
    assign rd_f[g]  = in_x[g*IW +: FRAC_WIDTH];
`else
    assign unused_frac[g] = ^in_x[g*IW +: FRAC_WIDTH];
`endif
  end

  // Stage 1: table operands captured on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        s1_t0_q[i] <= '0;
`ifdef SFU_LUT_INTERP_EN
        s1_t1_q[i] <= '0;
        s1_f_q[i]  <= '0;
`endif
      end
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          s1_t0_q[i] <= rd_t0[i];
`ifdef SFU_LUT_INTERP_EN
          s1_t1_q[i] <= rd_t1[i];
          s1_f_q[i]  <= rd_f[i];
`endif
        end
      end
    end
  end

`ifdef SFU_LUT_INTERP_EN
  // Signed slope times fraction, floored by the arithmetic shift.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_mul
    logic [DATA_WIDTH:0]    diff;
    logic signed [PW-1:0]   d_s;
    logic signed [PW-1:0]   f_s;
    logic signed [PW-1:0]   p_s;
    assign diff      = {1'b0, s1_t1_q[g]} - {1'b0, s1_t0_q[g]};
    assign d_s       = {{FRAC_WIDTH{diff[DATA_WIDTH]}}, diff};
    assign f_s       = {{(DATA_WIDTH+1){1'b0}}, s1_f_q[g]};
    assign p_s       = d_s * f_s;
    assign mul_dy[g] = DATA_WIDTH'(p_s >>> FRAC_WIDTH);
  end
`endif

  // Stage 2: base entry and scaled delta.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        s2_t0_q[i] <= '0;
`ifdef SFU_LUT_INTERP_EN
        s2_dy_q[i] <= '0;
`endif
      end
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          s2_t0_q[i] <= s1_t0_q[i];
`ifdef SFU_LUT_INTERP_EN
          s2_dy_q[i] <= mul_dy[i];
`endif
        end
      end
    end
  end

  // Final sum wraps modulo 2^DATA_WIDTH; the true result lies between t0 and t1.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_sum
`ifdef SFU_LUT_INTERP_EN
    assign y_d[g] = s2_t0_q[g] + s2_dy_q[g];
`else
    assign y_d[g] = s2_t0_q[g];
`endif
  end

  // Output register; holds value and valid while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else if (!stall) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          out_y_q[i*DATA_WIDTH +: DATA_WIDTH] <= y_d[i];
        end
      end
    end
  end

endmodule
